// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the Y86-64 sequential processor. It receives a framed
// byte stream over a valid/ready handshake and writes the payload into
// instruction memory starting at address 0, one byte per write. It then
// verifies an 8-bit checksum and raises cpu_run to release the processor.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N payload bytes, CSUM.
// The frame is good when (sum of payload + CSUM) mod 256 == 0.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    upstream byte valid
//   in_data     upstream byte
//   in_ready    loader accepts a byte this cycle (decoded from state only)
//   start       one-cycle pulse, re-arms the loader from DONE or ERROR
//   imem_we     instruction-memory write strobe, one cycle per payload byte
//   imem_addr   write address
//   imem_wdata  write data
//   byte_count  payload bytes written in the current frame
//   load_done   frame loaded with a good checksum (held)
//   load_err    frame rejected (held)
//   cpu_run     processor enable, equal to load_done
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic [ADDR_W:0]   byte_count,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_run
);

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // Largest legal payload length: the full memory.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  logic [2:0]        state_reg,  state_next;
  logic [7:0]        len_hi_reg, len_hi_next;
  logic [ADDR_W:0]   len_reg,    len_next;
  logic [ADDR_W:0]   index_reg,  index_next;
  logic [7:0]        sum_reg,    sum_next;
  logic              we_reg,     we_next;
  logic [ADDR_W-1:0] addr_reg,   addr_next;
  logic [7:0]        wdata_reg,  wdata_next;
  logic              done_reg,   done_next;
  logic              err_reg,    err_next;

  logic              accept;
  logic [16:0]       frame_len;
  logic [ADDR_W:0]   index_inc;
  logic [7:0]        sum_inc;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready  = (state_reg != ST_DONE) && (state_reg != ST_ERROR);
  assign accept    = in_valid && in_ready;

  // Full 16-bit length, zero-extended so the oversize test cannot overflow.
  assign frame_len = {1'b0, len_hi_reg, in_data};
  assign index_inc = index_reg + (ADDR_W+1)'(1);
  assign sum_inc   = sum_reg + in_data;

  always_comb begin
    state_next  = state_reg;
    len_hi_next = len_hi_reg;
    len_next    = len_reg;
    index_next  = index_reg;
    sum_next    = sum_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    done_next   = done_reg;
    err_next    = err_reg;

    case (state_reg)
      ST_SYNC: begin
        // Bytes other than the marker are silently dropped.
        if (accept && (in_data == SYNC_BYTE)) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_next = in_data;
          state_next  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          // Rejecting oversize lengths here guarantees the address never wraps.
          if ((frame_len == 17'd0) || (frame_len > CAPACITY)) begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end else begin
            len_next   = frame_len[ADDR_W:0];
            index_next = '0;
            sum_next   = 8'h00;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = index_reg[ADDR_W-1:0];
          wdata_next = in_data;
          index_next = index_inc;
          sum_next   = sum_inc;
          if (index_inc == len_reg) state_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (sum_inc == 8'h00) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          done_next  = 1'b0;
          err_next   = 1'b0;
          index_next = '0;
          state_next = ST_SYNC;
        end
      end
      default: begin
        state_next = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_SYNC;
      len_hi_reg <= 8'h00;
      len_reg    <= '0;
      index_reg  <= '0;
      sum_reg    <= 8'h00;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 8'h00;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_hi_reg <= len_hi_next;
      len_reg    <= len_next;
      index_reg  <= index_next;
      sum_reg    <= sum_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // The index doubles as the count of bytes already handed to memory.
  assign byte_count = index_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign load_done  = done_reg;
  assign load_err   = err_reg;
  assign cpu_run    = done_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed stimulus for imem_loader. A frame-level reference model derives
// the expected outputs from the list of bytes accepted since the loader was
// last armed; a compare process checks every output on every falling edge.
// Literal expectations after each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int         ADDR_W = 10;
  localparam int         CAP    = 1 << ADDR_W;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic [ADDR_W:0]   byte_count;
  logic              load_done;
  logic              load_err;
  logic              cpu_run;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .byte_count (byte_count),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_run    (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory scoreboard driven by the write port --------------
  logic [7:0] mem [0:CAP-1];
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
    end
  end

  // ---------------- frame-level reference model ----------------------------
  // m_frame holds the bytes accepted since arming, starting at the marker.
  logic [7:0] m_frame[$];
  logic       m_we;
  int         m_addr;
  logic [7:0] m_data;

  function automatic int m_len();
    return (int'(m_frame[1]) << 8) | int'(m_frame[2]);
  endfunction

  // 0 = still loading, 1 = done, 2 = error
  function automatic int m_status();
    int n;
    int s;
    if (m_frame.size() < 3) return 0;
    n = m_len();
    if (n == 0 || n > CAP) return 2;
    if (m_frame.size() < n + 4) return 0;
    s = 0;
    for (int i = 3; i < n + 4; i++) s += int'(m_frame[i]);
    return ((s % 256) == 0) ? 1 : 2;
  endfunction

  function automatic int m_count();
    int c;
    if (m_frame.size() <= 3) return 0;
    c = m_frame.size() - 3;
    if (c > m_len()) c = m_len();
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame.delete();
      m_we = 1'b0;
    end else begin
      int st;
      int pos;
      st   = m_status();
      m_we = 1'b0;
      if (st != 0) begin
        if (start) m_frame.delete();
      end else if (in_valid) begin
        if (m_frame.size() != 0 || in_data == SYNC) begin
          m_frame.push_back(in_data);
          pos = m_frame.size() - 1;
          if (pos >= 3 && pos < 3 + m_len()) begin
            m_we   = 1'b1;
            m_addr = pos - 3;
            m_data = in_data;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  always @(negedge clk) begin
    int st;
    st = m_status();
    chk("in_ready",   32'(in_ready),   32'(st == 0));
    chk("imem_we",    32'(imem_we),    32'(m_we));
    if (m_we) begin
      chk("imem_addr",  32'(imem_addr),  32'(m_addr));
      chk("imem_wdata", 32'(imem_wdata), 32'(m_data));
    end
    chk("byte_count", 32'(byte_count), 32'(m_count()));
    chk("load_done",  32'(load_done),  32'(st == 1));
    chk("load_err",   32'(load_err),   32'(st == 2));
    chk("cpu_run",    32'(cpu_run),    32'(st == 1));
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ---------
  logic [7:0] tx[$];

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(negedge clk);
  endtask

  task automatic send_tx(input int bubble_pct);
    foreach (tx[i]) begin
      if ($urandom_range(0, 99) < bubble_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send(tx[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    for (int i = 0; i < CAP; i++) mem[i] = 8'hEE;

    @(negedge clk);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr),  32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_cpu_run",    32'(cpu_run),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, then bytes offered while DONE must not be taken.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h00, 8'h03, 8'h30, 8'hF2, 8'h0A, 8'hD4};
    send_tx(0);
    chk("good_done_now", 32'(load_done), 32'd1);
    chk("good_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    idle(1);
    $display("good frame: done=%0b run=%0b count=%0d", load_done, cpu_run, byte_count);
    chk("good_mem0",   32'(mem[0]),     32'h30);
    chk("good_mem1",   32'(mem[1]),     32'hF2);
    chk("good_mem2",   32'(mem[2]),     32'h0A);
    chk("good_writes", 32'(wr_cnt - mark), 32'd3);
    chk("good_count",  32'(byte_count), 32'd3);
    chk("good_run",    32'(cpu_run),    32'd1);
    pulse_start();
    chk("rearm_ready", 32'(in_ready),   32'd1);
    chk("rearm_run",   32'(cpu_run),    32'd0);
    chk("rearm_count", 32'(byte_count), 32'd0);

    // Bad checksum: writes still happen.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h00};
    send_tx(0);
    idle(2);
    $display("bad csum: err=%0b run=%0b", load_err, cpu_run);
    chk("badcs_err",    32'(load_err), 32'd1);
    chk("badcs_run",    32'(cpu_run),  32'd0);
    chk("badcs_mem0",   32'(mem[0]),   32'h10);
    chk("badcs_mem1",   32'(mem[1]),   32'h20);
    chk("badcs_writes", 32'(wr_cnt - mark), 32'd2);
    pulse_start();
    chk("rearm_err", 32'(load_err), 32'd0);

    // Leading noise is discarded.
    mark = wr_cnt;
    tx = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
    send_tx(0);
    idle(2);
    $display("noise frame: done=%0b mem0=%0h", load_done, mem[0]);
    chk("noise_done",   32'(load_done), 32'd1);
    chk("noise_mem0",   32'(mem[0]),    32'h00);
    chk("noise_writes", 32'(wr_cnt - mark), 32'd1);
    pulse_start();

    // Zero length.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h00, 8'h00};
    send_tx(0);
    idle(2);
    $display("zero length: err=%0b", load_err);
    chk("zero_err",    32'(load_err), 32'd1);
    chk("zero_writes", 32'(wr_cnt - mark), 32'd0);
    pulse_start();

    // One byte over capacity.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h04, 8'h01};
    send_tx(0);
    idle(2);
    $display("oversize: err=%0b", load_err);
    chk("over_err",    32'(load_err), 32'd1);
    chk("over_writes", 32'(wr_cnt - mark), 32'd0);
    pulse_start();

    // Exactly full memory: payload i mod 256, sum is 0 so CSUM is 00.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h04, 8'h00};
    for (int i = 0; i < CAP; i++) tx.push_back(8'(i));
    tx.push_back(8'h00);
    send_tx(0);
    idle(2);
    $display("full frame: done=%0b count=%0d", load_done, byte_count);
    chk("full_done",    32'(load_done),  32'd1);
    chk("full_count",   32'(byte_count), 32'h400);
    chk("full_mem300",  32'(mem[300]),   32'h2C);
    chk("full_mem1023", 32'(mem[1023]),  32'hFF);
    chk("full_writes",  32'(wr_cnt - mark), 32'd1024);
    pulse_start();

    // 16-byte frame with random bubbles: payload 11*i, sum F8, CSUM 08.
    mark = wr_cnt;
    tx = '{8'hA5, 8'h00, 8'h10};
    s = 0;
    for (int i = 0; i < 16; i++) begin
      tx.push_back(8'(8'h11 * i));
      s += 8'h11 * i;
    end
    tx.push_back(8'h08);
    send_tx(40);
    idle(2);
    $display("bubbled frame: done=%0b count=%0d", load_done, byte_count);
    chk("bub_sum_model", 32'(s % 256),  32'hF8);
    chk("bub_done",   32'(load_done), 32'd1);
    chk("bub_mem7",   32'(mem[7]),    32'h77);
    chk("bub_mem15",  32'(mem[15]),   32'hFF);
    chk("bub_writes", 32'(wr_cnt - mark), 32'd16);
    pulse_start();

    // Reset while the second payload write is pending.
    tx = '{8'hA5, 8'h00, 8'h05, 8'hAA, 8'hBB};
    mem[1] = 8'h99;
    send_tx(0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: we=%0b count=%0d ready=%0b", imem_we, byte_count, in_ready);
    chk("arst_we",    32'(imem_we),    32'd0);
    chk("arst_addr",  32'(imem_addr),  32'd0);
    chk("arst_wdata", 32'(imem_wdata), 32'd0);
    chk("arst_count", 32'(byte_count), 32'd0);
    chk("arst_ready", 32'(in_ready),   32'd1);
    @(negedge clk);
    chk("arst_dropped", 32'(mem[1]), 32'h99);
    rst_n = 1'b1;
    @(negedge clk);

    tx = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'hA6};
    send_tx(0);
    idle(2);
    $display("post-reset frame: done=%0b mem0=%0h", load_done, mem[0]);
    chk("post_done",  32'(load_done),  32'd1);
    chk("post_mem0",  32'(mem[0]),     32'h5A);
    chk("post_count", 32'(byte_count), 32'd1);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the Y86-64 sequential processor: the write-side counterpart of the instruction-memory fetch path. It accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory from address 0, one byte per write. It verifies an 8-bit checksum and then asserts `cpu_run` to release the processor's PC/clock enable. This replaces file-based preloading of the instruction memory.

## Interface
- `ADDR_W`, default 10: instruction-memory byte address width; capacity is 2^ADDR_W bytes.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `start`  in  1  single-cycle pulse that re-arms the loader from DONE or ERROR.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per byte.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  8  write data.
- `byte_count`  out  ADDR_W+1  payload bytes written in the current frame.
- `load_done`  out  1  frame loaded with a good checksum; held.
- `load_err`  out  1  frame rejected; held.
- `cpu_run`  out  1  processor enable; equals `load_done`.

## Operation
- Frame format: `SYNC_BYTE`, LEN_HI, LEN_LO, then N payload bytes with N = {LEN_HI, LEN_LO}, then CSUM.
- A frame is good when the mod-256 sum of the payload bytes plus CSUM is 8'h00.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States and transitions:
  - SYNC: accepted byte == `SYNC_BYTE` -> LEN_HI. Any other byte is discarded and the state stays SYNC; this is not an error.
  - LEN_HI: latch the high length byte -> LEN_LO.
  - LEN_LO: latch the low byte. N == 0 or N > 2^ADDR_W -> ERROR. Otherwise clear the index and the running sum -> DATA.
  - DATA: each accepted byte is written at address = index; index and sum update. The state moves to CSUM after the Nth byte.
  - CSUM: compute sum + byte. Zero -> DONE, nonzero -> ERROR.
  - DONE: `load_done` = `cpu_run` = 1.
  - ERROR: `load_err` = 1 and `cpu_run` = 0.
  - `start` in DONE or ERROR -> SYNC; flags and `byte_count` clear. `start` in any other state is ignored.
- `in_ready` = 1 in SYNC, LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERROR.
- Arithmetic:
  - The length is 16 bits and the index counts to at most 2^ADDR_W, so `byte_count` is ADDR_W+1 bits.
  - `imem_addr` carries the low ADDR_W bits of the index. The address never wraps because oversize lengths are rejected at LEN_LO.
  - The checksum sum is 8 bits and wraps mod 256.
- The loader never clears memory. A failed frame leaves partially written contents in memory, and `cpu_run` stays 0.

## Timing
- Reset values: state SYNC, `in_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `byte_count` = 0, `load_done` = 0, `load_err` = 0, `cpu_run` = 0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). Any write strobe for the next edge is dropped.
- `in_ready` is decoded from the registered state, with no combinational path from `in_valid`. Full throughput is one byte per cycle.
- Write latency: a payload byte accepted at edge k drives `imem_we` = 1 with its address and data during cycle k+1, and the memory captures it at edge k+1. `imem_we` is 0 in every other cycle.
- `byte_count` increments on the same edge that registers the write.
- On the edge that accepts CSUM, `load_done`/`cpu_run` or `load_err` rises. `in_ready` falls on that same edge.
- The `start` transition to SYNC takes one edge. `cpu_run` is 0 in the following cycle and `in_ready` is 1.
- Back-to-back accepts, bubbles (`in_valid` = 0) and holding `in_valid` with `in_ready` = 0 are all legal. A byte is never consumed unless `in_ready` was 1.

## Test plan
- Good frame: A5 00 03 30 F2 0A D4 -> three writes (addr0 = 30, addr1 = F2, addr2 = 0A) on consecutive cycles; `byte_count` = 3; `load_done` = `cpu_run` = 1; `in_ready` = 0.
- Bad checksum: A5 00 02 10 20 00 -> `load_err` = 1 and `cpu_run` = 0. Two writes have still occurred, with addr0 = 10 and addr1 = 20.
- Framing errors:
  - Leading noise: 00 FF A5 00 01 00 00 -> noise discarded, one write of 00 at address 0, DONE.
  - Zero length: A5 00 00 -> ERROR.
  - Oversize length with ADDR_W = 10: A5 04 01 -> ERROR with no writes.
- Backpressure and bubbles: deassert `in_valid` randomly during a 16-byte frame -> writes remain in order at addresses 0..15 and the checksum passes. Bytes offered in DONE are not accepted.
- Re-arm: after ERROR, pulse `start` -> SYNC, flags 0, `in_ready` = 1. A subsequent good frame reaches DONE.
- Reset mid-operation: assert `rst_n` = 0 after 2 payload bytes of a 5-byte frame -> all outputs reset immediately. A fresh frame then loads correctly from address 0.
